unidade_controle_mc: RTL and testbench

//  Parametrised multicycle control FSM for the MIPS-subset datapath; successor to the fixed-count ADD/ADDI/RESET control unit.

---
 rtl/unidade_controle_mc.sv | 171 +++++++++++++++++
 tb/tb_unidade_controle_mc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_mc.sv
// Multicycle control FSM for the MIPS-subset datapath: memory-wait fetch, R-type/ADDI/BEQ/BNE/J,
// overflow exception and a timed reset hold. Outputs decode from the registered state.
module unidade_controle_mc #(
   parameter int unsigned MEM_WAIT = 3,
   parameter int unsigned RST_HOLD = 2,
   parameter logic [1:0]  EXC_SEL  = 2'b10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Of,
   input  logic       Ng,
   input  logic       Zr,
   input  logic       Eq,
   input  logic       Gt,
   input  logic       Lt,
   input  logic [5:0] OPCODE,
   input  logic [5:0] FUNCT,
   output logic       PC_w,
   output logic       MEM_w,
   output logic       IR_w,
   output logic       RB_w,
   output logic       AB_w,
   output logic       ALUOut_w,
   output logic       EPC_w,
   output logic [2:0] ULA_c,
   output logic       M_WREG,
   output logic       M_ULAA,
   output logic [1:0] M_ULAB,
   output logic [1:0] PC_src,
   output logic       rst_out
);

   localparam int unsigned CNT_MAX = (MEM_WAIT > RST_HOLD) ? MEM_WAIT : RST_HOLD;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_RESET, S_FETCH, S_DECODE, S_R_EXEC, S_I_EXEC, S_BRANCH, S_JUMP, S_OVF
   } state_t;

   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_AND, OP_BEQ, OP_BNE
   } op_t;

   state_t           state, next_state;
   op_t              op, next_op;
   logic [CNT_W-1:0] cnt;

   // Flags not consumed by this revision of the control unit.
   logic unused_flags;
   assign unused_flags = ^{Ng, Zr, Gt, Lt};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_RESET;
         op    <= OP_ADD;
         cnt   <= '0;
      end else begin
         state <= next_state;
         op    <= next_op;
         if (next_state != state)
            cnt <= '0;
         else if (cnt != CNT_W'(CNT_MAX))
            cnt <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      next_state = state;
      next_op    = op;
      PC_w       = 1'b0;
      MEM_w      = 1'b0;
      IR_w       = 1'b0;
      RB_w       = 1'b0;
      AB_w       = 1'b0;
      ALUOut_w   = 1'b0;
      EPC_w      = 1'b0;
      ULA_c      = 3'b000;
      M_WREG     = 1'b0;
      M_ULAA     = 1'b0;
      M_ULAB     = 2'b00;
      PC_src     = 2'b00;
      rst_out    = 1'b0;

      unique case (state)
         S_RESET: begin
            rst_out = 1'b1;
            if (cnt == CNT_W'(RST_HOLD - 1))
               next_state = S_FETCH;
         end
         S_FETCH: begin
            ULA_c  = 3'b001;
            M_ULAB = 2'b01;
            if (cnt == CNT_W'(MEM_WAIT)) begin
               PC_w       = 1'b1;
               IR_w       = 1'b1;
               next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            AB_w       = 1'b1;
            ALUOut_w   = 1'b1;
            ULA_c      = 3'b001;
            M_ULAB     = 2'b11;
            next_state = S_FETCH;
            case (OPCODE)
               6'b000000: begin
                  case (FUNCT)
                     6'b100000: begin next_op = OP_ADD; next_state = S_R_EXEC; end
                     6'b100010: begin next_op = OP_SUB; next_state = S_R_EXEC; end
                     6'b100100: begin next_op = OP_AND; next_state = S_R_EXEC; end
                     default:   next_state = S_FETCH;
                  endcase
               end
               6'b001000: next_state = S_I_EXEC;
               6'b000100: begin next_op = OP_BEQ; next_state = S_BRANCH; end
               6'b000101: begin next_op = OP_BNE; next_state = S_BRANCH; end
               6'b000010: next_state = S_JUMP;
               6'b111111: next_state = S_RESET;
               default:   next_state = S_FETCH;
            endcase
         end
         S_R_EXEC: begin
            M_ULAA = 1'b1;
            M_WREG = 1'b1;
            case (op)
               OP_SUB:  ULA_c = 3'b010;
               OP_AND:  ULA_c = 3'b011;
               default: ULA_c = 3'b001;
            endcase
            // AND cannot overflow, so it always writes back.
            if (Of && (op != OP_AND)) begin
               next_state = S_OVF;
            end else begin
               RB_w       = 1'b1;
               next_state = S_FETCH;
            end
         end
         S_I_EXEC: begin
            M_ULAA = 1'b1;
            M_ULAB = 2'b10;
            ULA_c  = 3'b001;
            if (Of) begin
               next_state = S_OVF;
            end else begin
               RB_w       = 1'b1;
               next_state = S_FETCH;
            end
         end
         S_BRANCH: begin
            ULA_c      = 3'b010;
            M_ULAA     = 1'b1;
            PC_src     = 2'b01;
            PC_w       = (op == OP_BNE) ? ~Eq : Eq;
            next_state = S_FETCH;
         end
         S_JUMP: begin
            PC_src     = 2'b11;
            PC_w       = 1'b1;
            next_state = S_FETCH;
         end
         S_OVF: begin
            EPC_w      = 1'b1;
            PC_src     = EXC_SEL;
            PC_w       = 1'b1;
            next_state = S_FETCH;
         end
         default: next_state = S_RESET;
      endcase
   end

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Bench for unidade_controle_mc: table of instructions feeding an expected-output scoreboard,
// plus hand-written reset, async-abort and MEM_WAIT=1 sequences.
module tb_unidade_controle_mc;

   logic       clk;
   logic       reset;
   logic       of0, eq0, of1;
   logic [5:0] opc0, fn0;
   logic [16:0] obs0, obs1;

   logic       pc_w0, mem_w0, ir_w0, rb_w0, ab_w0, ao_w0, epc_w0, wreg0, ulaa0, rst0;
   logic [2:0] ula0;
   logic [1:0] ulab0, pcs0;
   logic       pc_w1, mem_w1, ir_w1, rb_w1, ab_w1, ao_w1, epc_w1, wreg1, ulaa1, rst1;
   logic [2:0] ula1;
   logic [1:0] ulab1, pcs1;

   unidade_controle_mc dut0 (
      .clk(clk), .reset(reset), .Of(of0), .Ng(1'b0), .Zr(eq0), .Eq(eq0), .Gt(1'b0), .Lt(1'b0),
      .OPCODE(opc0), .FUNCT(fn0),
      .PC_w(pc_w0), .MEM_w(mem_w0), .IR_w(ir_w0), .RB_w(rb_w0), .AB_w(ab_w0), .ALUOut_w(ao_w0),
      .EPC_w(epc_w0), .ULA_c(ula0), .M_WREG(wreg0), .M_ULAA(ulaa0), .M_ULAB(ulab0),
      .PC_src(pcs0), .rst_out(rst0)
   );

   unidade_controle_mc #(.MEM_WAIT(1)) dut1 (
      .clk(clk), .reset(reset), .Of(of1), .Ng(1'b0), .Zr(1'b0), .Eq(1'b0), .Gt(1'b0), .Lt(1'b0),
      .OPCODE(6'b000000), .FUNCT(6'b100000),
      .PC_w(pc_w1), .MEM_w(mem_w1), .IR_w(ir_w1), .RB_w(rb_w1), .AB_w(ab_w1), .ALUOut_w(ao_w1),
      .EPC_w(epc_w1), .ULA_c(ula1), .M_WREG(wreg1), .M_ULAA(ulaa1), .M_ULAB(ulab1),
      .PC_src(pcs1), .rst_out(rst1)
   );

   assign obs0 = {pc_w0, mem_w0, ir_w0, rb_w0, ab_w0, ao_w0, epc_w0, ula0, wreg0, ulaa0, ulab0, pcs0, rst0};
   assign obs1 = {pc_w1, mem_w1, ir_w1, rb_w1, ab_w1, ao_w1, epc_w1, ula1, wreg1, ulaa1, ulab1, pcs1, rst1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] mk(input logic pc, mem, ir, rb, ab, ao, epc,
                                      input logic [2:0] ula, input logic wreg, ulaa,
                                      input logic [1:0] ulab, pcs, input logic rst);
      return {pc, mem, ir, rb, ab, ao, epc, ula, wreg, ulaa, ulab, pcs, rst};
   endfunction

   typedef struct {
      string       name;
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic        of;
      logic        eq;
      int          npost;
      logic [16:0] post0;
      logic [16:0] post1;
   } vec_t;

   typedef struct {
      string       name;
      logic [16:0] exp;
   } sb_t;

   vec_t vq[$];
   sb_t  sbq[$];
   int   total = 0;
   int   bad   = 0;

   logic [16:0] W_RST, W_FWAIT, W_FLOAD, W_DEC, W_OVF, W_JMP;
   logic [16:0] ADD_OK, ADD_NOWB, SUB_OK, SUB_NOWB, AND_OK, ADDI_OK, ADDI_NOWB, BR_TAKE, BR_NOT;

   task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%05h want=%05h", nm, act, exp);
      end
   endtask

   task automatic add_vec(input string nm, input logic [5:0] opc, input logic [5:0] fn,
                          input logic of, input logic eq, input int npost,
                          input logic [16:0] p0, input logic [16:0] p1);
      vec_t v;
      v.name = nm; v.opc = opc; v.fn = fn; v.of = of; v.eq = eq;
      v.npost = npost; v.post0 = p0; v.post1 = p1;
      vq.push_back(v);
   endtask

   task automatic push(input string nm, input logic [16:0] exp);
      sb_t s;
      s.name = nm; s.exp = exp;
      sbq.push_back(s);
   endtask

   // One cycle per expected word: compare at the negedge, step to just after the next posedge.
   task automatic run_cycles(input int n);
      sb_t s;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            s = sbq.pop_front();
            chk(s.name, obs0, s.exp);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_fetch_decode(input string nm);
      for (int i = 0; i < 3; i++) push({nm, "_fwait"}, W_FWAIT);
      push({nm, "_fload"}, W_FLOAD);
      push({nm, "_decode"}, W_DEC);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      W_RST     = mk(0,0,0,0,0,0,0, 3'b000, 0,0, 2'b00, 2'b00, 1);
      W_FWAIT   = mk(0,0,0,0,0,0,0, 3'b001, 0,0, 2'b01, 2'b00, 0);
      W_FLOAD   = mk(1,0,1,0,0,0,0, 3'b001, 0,0, 2'b01, 2'b00, 0);
      W_DEC     = mk(0,0,0,0,1,1,0, 3'b001, 0,0, 2'b11, 2'b00, 0);
      W_OVF     = mk(1,0,0,0,0,0,1, 3'b000, 0,0, 2'b00, 2'b10, 0);
      W_JMP     = mk(1,0,0,0,0,0,0, 3'b000, 0,0, 2'b00, 2'b11, 0);
      ADD_OK    = mk(0,0,0,1,0,0,0, 3'b001, 1,1, 2'b00, 2'b00, 0);
      ADD_NOWB  = mk(0,0,0,0,0,0,0, 3'b001, 1,1, 2'b00, 2'b00, 0);
      SUB_OK    = mk(0,0,0,1,0,0,0, 3'b010, 1,1, 2'b00, 2'b00, 0);
      SUB_NOWB  = mk(0,0,0,0,0,0,0, 3'b010, 1,1, 2'b00, 2'b00, 0);
      AND_OK    = mk(0,0,0,1,0,0,0, 3'b011, 1,1, 2'b00, 2'b00, 0);
      ADDI_OK   = mk(0,0,0,1,0,0,0, 3'b001, 0,1, 2'b10, 2'b00, 0);
      ADDI_NOWB = mk(0,0,0,0,0,0,0, 3'b001, 0,1, 2'b10, 2'b00, 0);
      BR_TAKE   = mk(1,0,0,0,0,0,0, 3'b010, 0,1, 2'b00, 2'b01, 0);
      BR_NOT    = mk(0,0,0,0,0,0,0, 3'b010, 0,1, 2'b00, 2'b01, 0);

      add_vec("add",       6'b000000, 6'b100000, 0, 0, 1, ADD_OK,    '0);
      add_vec("sub",       6'b000000, 6'b100010, 0, 0, 1, SUB_OK,    '0);
      add_vec("sub_ovf",   6'b000000, 6'b100010, 1, 0, 2, SUB_NOWB,  W_OVF);
      add_vec("add_ovf",   6'b000000, 6'b100000, 1, 0, 2, ADD_NOWB,  W_OVF);
      add_vec("and_of",    6'b000000, 6'b100100, 1, 0, 1, AND_OK,    '0);
      add_vec("rtype_bad", 6'b000000, 6'b101010, 0, 0, 0, '0,        '0);
      add_vec("addi",      6'b001000, 6'b000000, 0, 0, 1, ADDI_OK,   '0);
      add_vec("addi_ovf",  6'b001000, 6'b000000, 1, 0, 2, ADDI_NOWB, W_OVF);
      add_vec("beq_eq1",   6'b000100, 6'b000000, 0, 1, 1, BR_TAKE,   '0);
      add_vec("beq_eq0",   6'b000100, 6'b000000, 0, 0, 1, BR_NOT,    '0);
      add_vec("bne_eq1",   6'b000101, 6'b000000, 0, 1, 1, BR_NOT,    '0);
      add_vec("bne_eq0",   6'b000101, 6'b000000, 0, 0, 1, BR_TAKE,   '0);
      add_vec("jump",      6'b000010, 6'b000000, 0, 0, 1, W_JMP,     '0);
      add_vec("rst_op",    6'b111111, 6'b000000, 0, 0, 2, W_RST,     W_RST);
      add_vec("nop",       6'b010101, 6'b000000, 0, 0, 0, '0,        '0);
      add_vec("add_again", 6'b000000, 6'b100000, 0, 0, 1, ADD_OK,    '0);

      reset = 1'b0;
      of0 = 1'b0; eq0 = 1'b0; of1 = 1'b0;
      opc0 = 6'b010101; fn0 = 6'b000000;

      // Held in reset: reset-state outputs every cycle.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_low", obs0, W_RST);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      push("rst_hold", W_RST);
      push("rst_hold", W_RST);
      run_cycles(2);

      foreach (vq[k]) begin
         opc0 = vq[k].opc;
         fn0  = vq[k].fn;
         of0  = vq[k].of;
         eq0  = vq[k].eq;
         push_fetch_decode(vq[k].name);
         if (vq[k].npost > 0) push({vq[k].name, "_x0"}, vq[k].post0);
         if (vq[k].npost > 1) push({vq[k].name, "_x1"}, vq[k].post1);
         run_cycles(5 + vq[k].npost);
      end
      chk("sb_drain", 17'(sbq.size()), '0);

      // Asynchronous abort in the middle of an ADDI execute cycle.
      opc0 = 6'b001000; fn0 = 6'b000000; of0 = 1'b0; eq0 = 1'b0;
      push_fetch_decode("abort");
      run_cycles(5);
      chk("abort_iexec", obs0, ADDI_OK);
      #2 reset = 1'b0;
      #1 chk("abort_async", obs0, W_RST);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("abort_held", obs0, W_RST);
      end

      // MEM_WAIT=1 instance running ADD back to back: 4-cycle instruction period.
      @(posedge clk);
      #1 reset = 1'b1;
      for (int c = 0; c < 16; c++) begin
         logic [16:0] e;
         @(negedge clk);
         if (c < 2) e = W_RST;
         else begin
            case ((c - 2) % 4)
               0:       e = W_FWAIT;
               1:       e = W_FLOAD;
               2:       e = W_DEC;
               default: e = ADD_OK;
            endcase
         end
         chk("mw1_seq", obs1, e);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
